// File: rtl/m_seq_checker_if.sv
// -----------------------------------------------------------------------------
// m_seq_checker_if
//   Bundles the bit-stream input and the status outputs of m_seq_checker.
//
//   Handshake: din is a valid-only stream. A bit is accepted on a rising clk
//   edge exactly when din_valid is high. There is no ready: the checker
//   accepts every valid bit. err_clr is a level sampled on every edge,
//   independent of din_valid.
//
//   Signals:
//     din        received sequence bit
//     din_valid  din qualifier
//     err_clr    synchronous clear of err_cnt
//     locked     high while the checker is in LOCK
//     err        one-cycle pulse per detected bit error
//     err_cnt    saturating error count (CNT_W bits)
//
//   Modports: master = stream source / status consumer, slave = checker.
// -----------------------------------------------------------------------------
interface m_seq_checker_if #(
   parameter int CNT_W = 16
) ();
   logic             din;
   logic             din_valid;
   logic             err_clr;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output din, din_valid, err_clr,
      input  locked, err, err_cnt
   );

   modport slave (
      input  din, din_valid, err_clr,
      output locked, err, err_cnt
   );
endinterface

// File: rtl/m_seq_checker.sv
// -----------------------------------------------------------------------------
// m_seq_checker
//   Serial checker for the 5-stage m-sequence s[n] = s[n-2] ^ s[n-5]
//   (period 31). Fills a 5-bit history from the stream, verifies a run of
//   correct predictions, then locks and counts mismatches as bit errors.
//   Lock is dropped when too many errors land inside one 31-bit window.
//
//   Parameters:
//     VERIFY_LEN  consecutive matches needed to go VERIFY -> LOCK (1..255)
//     LOSS_THR    errors within one 31-bit window that force SEARCH (1..31)
//     CNT_W       err_cnt width
//
//   Ports:
//     clk        clock, rising edge
//     preset     synchronous active-low reset
//     bus        m_seq_checker_if.slave (din, din_valid, err_clr in;
//                locked, err, err_cnt out)
//     state_dbg  current FSM state (0 SEARCH, 1 VERIFY, 2 LOCK)
//
//   Build option:
//     M_SEQ_CHECKER_FLYWHEEL_EN  when defined, LOCK shifts the predicted bit
//     into the history instead of din, so a single flipped input bit gives a
//     single error. Otherwise LOCK stays self-synchronising on din and one
//     flipped bit shows up as three errors (n, n+2, n+5).
// -----------------------------------------------------------------------------
module m_seq_checker #(
   parameter int VERIFY_LEN = 8,
   parameter int LOSS_THR   = 4,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 preset,
   m_seq_checker_if.slave       bus,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [7:0]       VER_LAST  = 8'(VERIFY_LEN - 1);
   localparam logic [4:0]       LOSS_LAST = 5'(LOSS_THR - 1);
   localparam logic [4:0]       WIN_LAST  = 5'd30;

   state_t           state_q, state_d;
   logic [4:0]       h_q, h_d;        // h[0] is the newest accepted bit
   logic [2:0]       fill_q, fill_d;
   logic [7:0]       ver_q, ver_d;
   logic [4:0]       win_q, win_d;
   logic [4:0]       werr_q, werr_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             p;
   logic             mism;
   logic [4:0]       h_shift;

   always_ff @(posedge clk) begin
      if (!preset) begin
         state_q <= ST_SEARCH;
         h_q     <= '0;
         fill_q  <= '0;
         ver_q   <= '0;
         win_q   <= '0;
         werr_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         fill_q  <= fill_d;
         ver_q   <= ver_d;
         win_q   <= win_d;
         werr_q  <= werr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      fill_d  = fill_q;
      ver_d   = ver_q;
      win_d   = win_q;
      werr_d  = werr_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;

      p       = h_q[1] ^ h_q[4];
      mism    = bus.din ^ p;
      h_shift = {h_q[3:0], bus.din};

      if (bus.din_valid) begin
         case (state_q)
            ST_SEARCH: begin
               h_d = h_shift;
               if (fill_q == 3'd4) begin
                  // An all-zero history is the LFSR lock-up state; refill.
                  fill_d = 3'd0;
                  if (h_shift != 5'd0) begin
                     state_d = ST_VERIFY;
                     ver_d   = 8'd0;
                  end
               end else begin
                  fill_d = fill_q + 3'd1;
               end
            end
            ST_VERIFY: begin
               h_d = h_shift;
               if (mism) begin
                  state_d = ST_SEARCH;
                  fill_d  = 3'd0;
               end else if (ver_q == VER_LAST) begin
                  state_d = ST_LOCK;
                  win_d   = 5'd0;
                  werr_d  = 5'd0;
               end else begin
                  ver_d = ver_q + 8'd1;
               end
            end
            ST_LOCK: begin
`ifdef M_SEQ_CHECKER_FLYWHEEL_EN
               h_d = {h_q[3:0], p};
`else
               h_d = h_shift;
`endif
               err_d = mism;
               // The error that reaches the threshold drops lock on the same
               // edge; otherwise the window advances and clears at its wrap.
               if (mism && (werr_q == LOSS_LAST)) begin
                  state_d = ST_SEARCH;
                  fill_d  = 3'd0;
               end else if (win_q == WIN_LAST) begin
                  win_d  = 5'd0;
                  werr_d = 5'd0;
               end else begin
                  win_d  = win_q + 5'd1;
                  werr_d = werr_q + {4'd0, mism};
               end
            end
            default: begin
               state_d = ST_SEARCH;
               fill_d  = 3'd0;
            end
         endcase
      end

      // A clear that coincides with an error leaves that error counted.
      if (bus.err_clr) begin
         cnt_d    = '0;
         cnt_d[0] = err_d;
      end else if (err_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign bus.locked  = (state_q == ST_LOCK);
   assign bus.err     = err_q;
   assign bus.err_cnt = cnt_q;
   assign state_dbg   = state_q;

endmodule
